// File: rtl/regfile_port_sched_if.sv
// Core, debug and Regfile signals seen by regfile_port_sched.
// The slave modport is the scheduler's view; master is the surrounding logic.
interface regfile_port_sched_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] i_coreRs1Addr;
  logic [ADDR_WIDTH-1:0] i_coreRs2Addr;
  logic [ADDR_WIDTH-1:0] i_coreRdAddr;
  logic [DATA_WIDTH-1:0] i_coreRdData;
  logic                  i_coreWrEn;
  logic                  o_coreStall;
  logic                  o_initDone;

  logic [ADDR_WIDTH-1:0] o_rs1Addr;
  logic [ADDR_WIDTH-1:0] o_rs2Addr;
  logic [ADDR_WIDTH-1:0] o_rdAddr;
  logic [DATA_WIDTH-1:0] o_rdData;
  logic                  o_wrEn;
  logic [DATA_WIDTH-1:0] i_rs1Data;

  logic                  i_dbgReq;
  logic                  i_dbgWe;
  logic [ADDR_WIDTH-1:0] i_dbgAddr;
  logic [DATA_WIDTH-1:0] i_dbgWdata;
  logic                  o_dbgAck;
  logic [DATA_WIDTH-1:0] o_dbgRdata;

  modport slave (
    input  i_coreRs1Addr, i_coreRs2Addr, i_coreRdAddr, i_coreRdData, i_coreWrEn,
    input  i_rs1Data, i_dbgReq, i_dbgWe, i_dbgAddr, i_dbgWdata,
    output o_coreStall, o_initDone, o_rs1Addr, o_rs2Addr, o_rdAddr, o_rdData, o_wrEn,
    output o_dbgAck, o_dbgRdata
  );

  modport master (
    output i_coreRs1Addr, i_coreRs2Addr, i_coreRdAddr, i_coreRdData, i_coreWrEn,
    output i_rs1Data, i_dbgReq, i_dbgWe, i_dbgAddr, i_dbgWdata,
    input  o_coreStall, o_initDone, o_rs1Addr, o_rs2Addr, o_rdAddr, o_rdData, o_wrEn,
    input  o_dbgAck, o_dbgRdata
  );
endinterface

// File: rtl/regfile_port_sched.sv
// Regfile port arbiter: clears all registers after reset, then shares the ports between core and debug.
// Latency: debug read acks 3 cycles after being seen in IDLE, uncontended debug write acks next cycle.
// Backpressure: o_coreStall holds the core during clear, debug reads, and starved debug writes.
module regfile_port_sched #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int STARVE_LIMIT = 8
) (
  input logic                 i_clk,
  input logic                 i_rst,
  regfile_port_sched_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [2:0] {CLEAR, IDLE, DBG_RD, DBG_CAP, DBG_DONE} state_t;

  state_t                state, nextState;
  logic [ADDR_WIDTH-1:0] clrCnt;
  logic [SW-1:0]         starveCnt;
  logic                  initDone, dbgAck;
  logic [DATA_WIDTH-1:0] dbgRdata;

  logic                  dbgWrReq, starved, dbgWrGrant, clrLast;
  logic [ADDR_WIDTH-1:0] rs1Addr, rs2Addr, rdAddr;
  logic [DATA_WIDTH-1:0] rdData;
  logic                  wrEn, stall;

  assign dbgWrReq   = bus.i_dbgReq & bus.i_dbgWe;
  assign starved    = (starveCnt == SW'(STARVE_LIMIT));
  assign dbgWrGrant = (state == IDLE) & dbgWrReq & (~bus.i_coreWrEn | starved);
  assign clrLast    = (clrCnt == {ADDR_WIDTH{1'b1}});

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= CLEAR;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      CLEAR:    if (clrLast) nextState = IDLE;
      IDLE: begin
        if (bus.i_dbgReq && !bus.i_dbgWe) nextState = DBG_RD;
        else if (dbgWrGrant)              nextState = DBG_DONE;
      end
      DBG_RD:   nextState = DBG_CAP;
      DBG_CAP:  nextState = DBG_DONE;
      DBG_DONE: nextState = IDLE;
      default:  nextState = CLEAR;
    endcase
  end

  always_comb begin
    rs1Addr = bus.i_coreRs1Addr;
    rs2Addr = bus.i_coreRs2Addr;
    rdAddr  = bus.i_coreRdAddr;
    rdData  = bus.i_coreRdData;
    wrEn    = 1'b0;
    stall   = 1'b0;
    case (state)
      CLEAR: begin
        rdAddr = clrCnt;
        rdData = '0;
        wrEn   = 1'b1;
        stall  = 1'b1;
      end
      IDLE: begin
        if (dbgWrGrant) begin
          // A starved grant steals the port from a live core write, so the core must hold it.
          rdAddr = bus.i_dbgAddr;
          rdData = bus.i_dbgWdata;
          wrEn   = (bus.i_dbgAddr != '0);
          stall  = bus.i_coreWrEn;
        end else begin
          wrEn   = bus.i_coreWrEn & (bus.i_coreRdAddr != '0);
        end
      end
      DBG_RD: begin
        rs1Addr = bus.i_dbgAddr;
        stall   = 1'b1;
      end
      DBG_CAP:  stall = 1'b1;
      DBG_DONE: wrEn  = bus.i_coreWrEn & (bus.i_coreRdAddr != '0);
      default:  stall = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      clrCnt    <= '0;
      starveCnt <= '0;
      initDone  <= 1'b0;
      dbgAck    <= 1'b0;
      dbgRdata  <= '0;
    end else begin
      if (state == CLEAR) clrCnt <= clrCnt + 1'b1;
      if (state == CLEAR && clrLast) initDone <= 1'b1;
      dbgAck <= (nextState == DBG_DONE);
      if (state == DBG_CAP) dbgRdata <= bus.i_rs1Data;
      if (!bus.i_dbgReq || dbgWrGrant)
        starveCnt <= '0;
      else if (state == IDLE && dbgWrReq && bus.i_coreWrEn)
        starveCnt <= starveCnt + 1'b1;
    end
  end

  assign bus.o_rs1Addr   = rs1Addr;
  assign bus.o_rs2Addr   = rs2Addr;
  assign bus.o_rdAddr    = rdAddr;
  assign bus.o_rdData    = rdData;
  assign bus.o_wrEn      = wrEn;
  assign bus.o_coreStall = stall;
  assign bus.o_initDone  = initDone;
  assign bus.o_dbgAck    = dbgAck;
  assign bus.o_dbgRdata  = dbgRdata;
endmodule

// File: tb/tb_regfile_port_sched.sv
// Directed bench for regfile_port_sched with a behavioural 2R/1W write-through Regfile attached.
module tb_regfile_port_sched;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  regfile_port_sched_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  regfile_port_sched #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .STARVE_LIMIT(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Regfile model: synchronous read, write-through on address match.
  logic [31:0] rf [32];
  logic [31:0] rs2Data;
  always_ff @(posedge clk) begin
    if (bus.o_wrEn) rf[bus.o_rdAddr] <= bus.o_rdData;
    bus.i_rs1Data <= (bus.o_wrEn && bus.o_rdAddr == bus.o_rs1Addr) ? bus.o_rdData : rf[bus.o_rs1Addr];
    rs2Data       <= (bus.o_wrEn && bus.o_rdAddr == bus.o_rs2Addr) ? bus.o_rdData : rf[bus.o_rs2Addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  int   n;
  logic stallOk, ackSeen;

  initial begin
    bus.i_coreRs1Addr = '0; bus.i_coreRs2Addr = '0; bus.i_coreRdAddr = '0;
    bus.i_coreRdData  = '0; bus.i_coreWrEn    = 1'b0;
    bus.i_dbgReq = 1'b0; bus.i_dbgWe = 1'b0; bus.i_dbgAddr = '0; bus.i_dbgWdata = '0;

    // 1: reset state, clear sweep length, registers cleared
    #1 rst = 1'b1;
    settle();
    chkb("rst_stall", bus.o_coreStall, 1'b1);
    chkb("rst_initDone", bus.o_initDone, 1'b0);
    chkb("rst_ack", bus.o_dbgAck, 1'b0);
    chk("rst_dbgRdata", bus.o_dbgRdata, 32'h0);
    chkb("rst_wrEn", bus.o_wrEn, 1'b1);
    chk("rst_rdAddr", 32'(bus.o_rdAddr), 32'd0);
    tick();
    rst = 1'b0;
    n = 0; stallOk = 1'b1;
    while (!bus.o_initDone && n < 40) begin
      if (!bus.o_coreStall) stallOk = 1'b0;
      tick();
      n++;
    end
    chk("init_cycles", n, 32);
    chkb("clear_stall", stallOk, 1'b1);
    chkb("idle_stall", bus.o_coreStall, 1'b0);
    for (int i = 0; i < 32; i++) begin
      bus.i_coreRs1Addr = 5'(i);
      tick();
      chk("clear_read", bus.i_rs1Data, 32'h0);
    end

    // 2: core writes, x0 gated
    bus.i_coreWrEn = 1'b1; bus.i_coreRdAddr = 5'd5; bus.i_coreRdData = 32'hdeadbeef;
    settle();
    chkb("core_wr_x5_en", bus.o_wrEn, 1'b1);
    tick();
    bus.i_coreRdAddr = 5'd0; bus.i_coreRdData = 32'h12345678;
    settle();
    chkb("core_wr_x0_gated", bus.o_wrEn, 1'b0);
    tick();
    bus.i_coreWrEn = 1'b0; bus.i_coreRs1Addr = 5'd5; bus.i_coreRs2Addr = 5'd0;
    tick();
    chk("rd_x5", bus.i_rs1Data, 32'hdeadbeef);
    chk("rd_x0", rs2Data, 32'h0);

    // 3: debug read x5
    bus.i_coreRs1Addr = 5'd0;
    bus.i_dbgReq = 1'b1; bus.i_dbgWe = 1'b0; bus.i_dbgAddr = 5'd5;
    settle();
    chkb("dbgrd_c0_stall", bus.o_coreStall, 1'b0);
    tick();
    chkb("dbgrd_c1_stall", bus.o_coreStall, 1'b1);
    chk("dbgrd_c1_rs1Addr", 32'(bus.o_rs1Addr), 32'd5);
    chkb("dbgrd_c1_ack", bus.o_dbgAck, 1'b0);
    tick();
    chkb("dbgrd_c2_stall", bus.o_coreStall, 1'b1);
    chk("dbgrd_c2_rs1Addr", 32'(bus.o_rs1Addr), 32'd0);
    chkb("dbgrd_c2_wrEn", bus.o_wrEn, 1'b0);
    chkb("dbgrd_c2_ack", bus.o_dbgAck, 1'b0);
    tick();
    chkb("dbgrd_c3_ack", bus.o_dbgAck, 1'b1);
    chkb("dbgrd_c3_stall", bus.o_coreStall, 1'b0);
    chk("dbgrd_rdata", bus.o_dbgRdata, 32'hdeadbeef);
    chk("dbgrd_core_rs1", bus.i_rs1Data, 32'h0);
    bus.i_dbgReq = 1'b0;
    tick();
    chkb("dbgrd_ack_pulse", bus.o_dbgAck, 1'b0);
    chk("dbgrd_rdata_hold", bus.o_dbgRdata, 32'hdeadbeef);

    // 4: debug write starved by back-to-back core writes
    bus.i_dbgReq = 1'b1; bus.i_dbgWe = 1'b1; bus.i_dbgAddr = 5'd7; bus.i_dbgWdata = 32'hcafed00d;
    for (int k = 1; k <= 8; k++) begin
      bus.i_coreWrEn = 1'b1; bus.i_coreRdAddr = 5'(9 + k); bus.i_coreRdData = 32'h100 + 32'(k);
      settle();
      chkb("starve_nostall", bus.o_coreStall, 1'b0);
      chk("starve_core_addr", 32'(bus.o_rdAddr), 32'(9 + k));
      tick();
    end
    bus.i_coreRdAddr = 5'd18; bus.i_coreRdData = 32'h109;
    settle();
    chkb("starve_c9_stall", bus.o_coreStall, 1'b1);
    chk("starve_c9_addr", 32'(bus.o_rdAddr), 32'd7);
    chk("starve_c9_data", bus.o_rdData, 32'hcafed00d);
    chkb("starve_c9_wrEn", bus.o_wrEn, 1'b1);
    chkb("starve_c9_ack", bus.o_dbgAck, 1'b0);
    tick();
    chkb("starve_ack", bus.o_dbgAck, 1'b1);
    chkb("starve_done_stall", bus.o_coreStall, 1'b0);
    chk("starve_c10_addr", 32'(bus.o_rdAddr), 32'd18);
    chkb("starve_c10_wrEn", bus.o_wrEn, 1'b1);
    bus.i_dbgReq = 1'b0;
    tick();
    bus.i_coreWrEn = 1'b0; bus.i_coreRs1Addr = 5'd7; bus.i_coreRs2Addr = 5'd18;
    tick();
    chk("rd_x7", bus.i_rs1Data, 32'hcafed00d);
    chk("rd_x18", rs2Data, 32'h109);
    bus.i_coreRs1Addr = 5'd17; bus.i_coreRs2Addr = 5'd10;
    tick();
    chk("rd_x17", bus.i_rs1Data, 32'h108);
    chk("rd_x10", rs2Data, 32'h101);

    // 5: uncontended debug write
    bus.i_dbgReq = 1'b1; bus.i_dbgWe = 1'b1; bus.i_dbgAddr = 5'd3; bus.i_dbgWdata = 32'h8badf00d;
    settle();
    chkb("dbgwr_stall", bus.o_coreStall, 1'b0);
    chkb("dbgwr_wrEn", bus.o_wrEn, 1'b1);
    chk("dbgwr_addr", 32'(bus.o_rdAddr), 32'd3);
    tick();
    chkb("dbgwr_ack", bus.o_dbgAck, 1'b1);
    bus.i_dbgReq = 1'b0; bus.i_coreRs1Addr = 5'd3;
    tick();
    chk("rd_x3", bus.i_rs1Data, 32'h8badf00d);

    // 6: reset during DBG_CAP aborts the read and restarts the sweep
    bus.i_coreRs1Addr = 5'd0;
    bus.i_dbgReq = 1'b1; bus.i_dbgWe = 1'b0; bus.i_dbgAddr = 5'd5;
    tick();
    tick();
    rst = 1'b1;
    settle();
    chkb("abort_stall", bus.o_coreStall, 1'b1);
    chkb("abort_ack", bus.o_dbgAck, 1'b0);
    chkb("abort_initDone", bus.o_initDone, 1'b0);
    chk("abort_clr_addr", 32'(bus.o_rdAddr), 32'd0);
    tick();
    chkb("abort_ack_later", bus.o_dbgAck, 1'b0);
    rst = 1'b0; bus.i_dbgReq = 1'b0;
    n = 0; ackSeen = 1'b0;
    while (!bus.o_initDone && n < 40) begin
      if (bus.o_dbgAck) ackSeen = 1'b1;
      tick();
      n++;
    end
    chk("reinit_cycles", n, 32);
    chkb("reinit_no_ack", ackSeen, 1'b0);
    bus.i_coreRs1Addr = 5'd5; bus.i_coreRs2Addr = 5'd7;
    tick();
    chk("reinit_x5", bus.i_rs1Data, 32'h0);
    chk("reinit_x7", rs2Data, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
